// File: rtl/simon_sequence_engine.sv
// rtl/simon_sequence_engine.sv - Simon pattern sequencer: append a colour, play the pattern, check presses
module simon_sequence_engine #(
  parameter int MAX_LEN = 16,
  parameter int LED_ON  = 20,
  parameter int LED_OFF = 10,
  parameter int TIMEOUT = 1000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [3:0]               i_rand_4_bit_encoding,
  input  logic [3:0]               i_btn,
  output logic [3:0]               o_led,
  output logic [$clog2(MAX_LEN):0] o_round,
  output logic                     o_busy,
  output logic                     o_listening,
  output logic                     o_win,
  output logic                     o_lose
);
  localparam int IW    = $clog2(MAX_LEN);
  localparam int RW    = IW + 1;
  localparam int T_ONF = (LED_ON > LED_OFF) ? LED_ON : LED_OFF;
  localparam int T_MAX = (TIMEOUT > T_ONF) ? TIMEOUT : T_ONF;
  localparam int TW    = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_APPEND, S_SHOW_ON, S_SHOW_OFF, S_LISTEN, S_WIN, S_LOSE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [RW-1:0] r_round, w_round_nxt;
  logic [1:0]    r_mem [MAX_LEN];
  logic          w_mem_we;
  logic [1:0]    w_rand_idx;
  logic [1:0]    w_show_col;
  logic [3:0]    w_expect;
  logic          w_last_step;

  logic [3:0]    r_led, w_led_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_listening, w_listening_nxt;
  logic          r_win, w_win_nxt;
  logic          r_lose, w_lose_nxt;

  assign w_expect    = 4'b0001 << r_mem[r_idx];
  assign w_last_step = ({1'b0, r_idx} + RW'(1)) == r_round;

  // Colour index from the lfsr: lowest set bit wins, all-zero maps to index 0
  always_comb begin
    w_rand_idx = 2'd0;
    if (i_rand_4_bit_encoding[0])      w_rand_idx = 2'd0;
    else if (i_rand_4_bit_encoding[1]) w_rand_idx = 2'd1;
    else if (i_rand_4_bit_encoding[2]) w_rand_idx = 2'd2;
    else if (i_rand_4_bit_encoding[3]) w_rand_idx = 2'd3;
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and datapath next values
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_timer_nxt = r_timer;
    w_round_nxt = r_round;
    w_mem_we    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_round_nxt = '0;
          w_state_nxt = S_APPEND;
        end
      end
      S_APPEND: begin
        w_mem_we    = 1'b1;
        w_round_nxt = r_round + RW'(1);
        w_idx_nxt   = '0;
        w_timer_nxt = '0;
        w_state_nxt = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (r_timer == TW'(LED_ON - 1)) begin
          w_timer_nxt = '0;
          w_state_nxt = S_SHOW_OFF;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_SHOW_OFF: begin
        if (r_timer == TW'(LED_OFF - 1)) begin
          w_timer_nxt = '0;
          if (w_last_step) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_LISTEN;
          end else begin
            w_idx_nxt   = r_idx + IW'(1);
            w_state_nxt = S_SHOW_ON;
          end
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_LISTEN: begin
        // A press always beats the timeout on the same cycle
        if (i_btn != 4'b0000) begin
          if (i_btn == w_expect) begin
            w_timer_nxt = '0;
            if (w_last_step) begin
              w_state_nxt = (r_round == RW'(MAX_LEN)) ? S_WIN : S_APPEND;
            end else begin
              w_idx_nxt = r_idx + IW'(1);
            end
          end else begin
            w_state_nxt = S_LOSE;
          end
        end else if (r_timer == TW'(TIMEOUT - 1)) begin
          w_state_nxt = S_LOSE;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_WIN:   w_state_nxt = S_IDLE;
      S_LOSE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output next values, derived from the state being entered so they line up with it
  always_comb begin
    // mem[0] is being written on the APPEND of the first round, so forward the fresh colour
    w_show_col      = (r_state == S_APPEND && r_round == '0) ? w_rand_idx : r_mem[w_idx_nxt];
    w_led_nxt       = (w_state_nxt == S_SHOW_ON) ? (4'b0001 << w_show_col) : 4'b0000;
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_listening_nxt = (w_state_nxt == S_LISTEN);
    w_win_nxt       = (w_state_nxt == S_WIN);
    w_lose_nxt      = (w_state_nxt == S_LOSE);
  end

  // Datapath registers: step index, shared cycle timer, pattern length
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx   <= '0;
      r_timer <= '0;
      r_round <= '0;
    end else begin
      r_idx   <= w_idx_nxt;
      r_timer <= w_timer_nxt;
      r_round <= w_round_nxt;
    end
  end

  // Pattern memory; contents are meaningless until written, so no reset
  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[r_round[IW-1:0]] <= w_rand_idx;
  end

  // Registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_led       <= 4'b0000;
      r_busy      <= 1'b0;
      r_listening <= 1'b0;
      r_win       <= 1'b0;
      r_lose      <= 1'b0;
    end else begin
      r_led       <= w_led_nxt;
      r_busy      <= w_busy_nxt;
      r_listening <= w_listening_nxt;
      r_win       <= w_win_nxt;
      r_lose      <= w_lose_nxt;
    end
  end

  assign o_led       = r_led;
  assign o_round     = r_round;
  assign o_busy      = r_busy;
  assign o_listening = r_listening;
  assign o_win       = r_win;
  assign o_lose      = r_lose;

endmodule

// File: tb/tb_simon_sequence_engine.sv
// tb/tb_simon_sequence_engine.sv - randomized self-checking bench for simon_sequence_engine
module tb_simon_sequence_engine;
  localparam int MAXL = 4;
  localparam int LON  = 20;
  localparam int LOFF = 10;
  localparam int TOUT = 1000;
  localparam int RW   = $clog2(MAXL) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    rnd = 4'b0000;
  logic [3:0]    btn = 4'b0000;
  logic [3:0]    o_led;
  logic [RW-1:0] o_round;
  logic          o_busy, o_listening, o_win, o_lose;

  always #5 clk = ~clk;

  simon_sequence_engine #(
    .MAX_LEN(MAXL), .LED_ON(LON), .LED_OFF(LOFF), .TIMEOUT(TOUT)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_rand_4_bit_encoding(rnd),
    .i_btn(btn),
    .o_led(o_led),
    .o_round(o_round),
    .o_busy(o_busy),
    .o_listening(o_listening),
    .o_win(o_win),
    .o_lose(o_lose)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int lose_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Game-level model: the pattern as a queue, playback as a queue of per-cycle LED values
  typedef enum int {M_IDLE, M_APPEND, M_PLAY, M_LISTEN, M_END} mph_t;
  mph_t          m_ph = M_IDLE;
  logic [3:0]    pat[$];
  logic [3:0]    wave[$];
  int            pos = 0;
  int            tmr = 0;
  logic [3:0]    e_led = 0;
  logic [RW-1:0] e_round = 0;
  logic          e_busy = 0, e_listen = 0, e_win = 0, e_lose = 0;

  function automatic logic [3:0] lowest(input logic [3:0] r);
    if (r == 4'b0000) return 4'b0001;
    return r & (~r + 4'd1);
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_ph = M_IDLE; pat.delete(); wave.delete();
      e_led = 0; e_round = 0; e_busy = 0; e_listen = 0; e_win = 0; e_lose = 0;
    end else begin
      e_win = 0;
      e_lose = 0;
      case (m_ph)
        M_IDLE: if (start) begin
          pat.delete(); e_round = 0; e_busy = 1; m_ph = M_APPEND;
        end
        M_APPEND: begin
          pat.push_back(lowest(rnd));
          e_round = RW'(pat.size());
          wave.delete();
          foreach (pat[k]) begin
            repeat (LON) wave.push_back(pat[k]);
            repeat (LOFF) wave.push_back(4'b0000);
          end
          e_led = wave.pop_front();
          m_ph = M_PLAY;
        end
        M_PLAY: begin
          if (wave.size() == 0) begin
            e_led = 0; e_listen = 1; pos = 0; tmr = 0; m_ph = M_LISTEN;
          end else begin
            e_led = wave.pop_front();
          end
        end
        M_LISTEN: begin
          if (btn != 4'b0000) begin
            if (btn == pat[pos]) begin
              pos++;
              tmr = 0;
              if (pos == pat.size()) begin
                e_listen = 0;
                if (pat.size() == MAXL) begin e_win = 1; m_ph = M_END; end
                else m_ph = M_APPEND;
              end
            end else begin
              e_lose = 1; e_listen = 0; m_ph = M_END;
            end
          end else begin
            tmr++;
            if (tmr == TOUT) begin e_lose = 1; e_listen = 0; m_ph = M_END; end
          end
        end
        M_END: begin e_busy = 0; m_ph = M_IDLE; end
        default: m_ph = M_IDLE;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (o_lose) lose_cnt++;
      check("cycle_outputs{led,round,busy,listen,win,lose}",
            {o_led, o_round, o_busy, o_listening, o_win, o_lose},
            {e_led, e_round, e_busy, e_listen, e_win, e_lose});
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic press(input logic [3:0] b);
    btn = b; @(negedge clk); btn = 4'b0000;
  endtask

  task automatic wait_phase(input mph_t p, input string name);
    int n = 0;
    while (m_ph != p && n < 3000) begin @(negedge clk); n++; end
    if (m_ph != p) begin
      n_checks++;
      $display("FAIL %s: wait budget expired, phase %0d required %0d", name, m_ph, p);
    end
  endtask

  task automatic wait_listen_noisy();
    int n = 0;
    while (m_ph != M_LISTEN && n < 3000) begin
      if ($urandom_range(0, 15) == 0) press(4'($urandom));
      else tick(1);
      n++;
    end
    if (m_ph != M_LISTEN) begin
      n_checks++;
      $display("FAIL noisy_wait_listen: wait budget expired, phase %0d", m_ph);
    end
  endtask

  initial begin
    int n, lit, len, c, alive;
    logic [3:0] w;

    // Reset state
    tick(2);
    check("reset_outputs", {o_led, o_round, o_busy, o_listening, o_win, o_lose}, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // 1: async reset in the middle of playback
    rnd = 4'b0100;
    do_start();
    tick(5);
    check("t1_led_before_reset", o_led, 4'b0100);
    #3 rst_n = 1'b0;
    #1;
    check("t1_async_led", o_led, 4'b0000);
    check("t1_async_round", o_round, 0);
    check("t1_async_busy", o_busy, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // 2: first-round latency and playback timing, then a two-step round
    rnd = 4'b0100;
    do_start();
    check("t2_busy_in_append", o_busy, 1);
    tick(1);
    check("t2_first_led", o_led, 4'b0100);
    check("t2_round1", o_round, 1);
    tick(19);
    check("t2_last_lit_cycle", o_led, 4'b0100);
    tick(1);
    check("t2_first_dark_cycle", o_led, 4'b0000);
    tick(9);
    check("t2_not_listening_yet", o_listening, 0);
    tick(1);
    check("t2_listening", o_listening, 1);
    press(4'b0100);
    lit = 0; n = 0;
    while (m_ph != M_LISTEN && n < 200) begin
      if (o_led == 4'b0100) lit++;
      tick(1); n++;
    end
    check("t2_round2_lit_cycles", lit, 2 * LON);
    check("t2_round2", o_round, 2);
    press(4'b0001);
    check("t2_wrong_press_lose", o_lose, 1);
    wait_phase(M_IDLE, "t2_idle");

    // 3: wrong press in round 1
    rnd = 4'b0001;
    do_start();
    wait_phase(M_LISTEN, "t3_listen");
    press(4'b0010);
    check("t3_lose_pulse", o_lose, 1);
    tick(1);
    check("t3_lose_one_cycle", o_lose, 0);
    check("t3_busy_low", o_busy, 0);
    check("t3_round_held", o_round, 1);

    // 4: timeout after exactly TOUT cycles of listening
    rnd = 4'b0010;
    do_start();
    wait_phase(M_LISTEN, "t4_listen");
    n = 0;
    while (!o_lose && n < TOUT + 100) begin tick(1); n++; end
    check("t4_timeout_cycles", n, TOUT);
    tick(2);

    // 4b: press on the last allowed cycle beats the timeout
    rnd = 4'b1000;
    do_start();
    wait_phase(M_LISTEN, "t4b_listen");
    tick(TOUT - 1);
    press(4'b1000);
    check("t4b_no_lose", o_lose, 0);
    check("t4b_still_busy", o_busy, 1);
    wait_phase(M_LISTEN, "t4b_listen2");
    press(4'b0001);
    wait_phase(M_IDLE, "t4b_idle");

    // 5: alternating colours, every press correct, through to a win
    lose_cnt = 0;
    rnd = 4'b0001;
    do_start();
    for (int r = 0; r < MAXL; r++) begin
      wait_phase(M_LISTEN, "t5_listen");
      len = pat.size();
      for (int p = 0; p < len; p++) begin
        tick($urandom_range(0, 3));
        if (p == len - 1) rnd = (r % 2 == 0) ? 4'b1000 : 4'b0001;
        press(pat[p]);
      end
    end
    check("t5_win_pulse", o_win, 1);
    check("t5_round_final", o_round, MAXL);
    check("t5_pattern", {pat[0], pat[1], pat[2], pat[3]}, 16'h1818);
    tick(1);
    check("t5_win_one_cycle", o_win, 0);
    check("t5_idle_busy", o_busy, 0);
    check("t5_never_lose", lose_cnt, 0);

    // 6: start ignored while busy, multi-bit press loses
    rnd = 4'b0010;
    do_start();
    tick(5);
    do_start();
    check("t6_round_unchanged", o_round, 1);
    check("t6_led_unchanged", o_led, 4'b0010);
    wait_phase(M_LISTEN, "t6_listen");
    press(4'b0011);
    check("t6_multibit_lose", o_lose, 1);
    wait_phase(M_IDLE, "t6_idle");

    // Random games: arbitrary lfsr values, noise during playback, random mistakes
    for (int g = 0; g < 12; g++) begin
      rnd = 4'($urandom);
      do_start();
      alive = 1;
      while (alive != 0) begin
        wait_listen_noisy();
        len = pat.size();
        for (int p = 0; p < len && alive != 0; p++) begin
          tick($urandom_range(0, 4));
          c = $urandom_range(0, 99);
          if (c < 5) begin
            do w = 4'($urandom_range(1, 15)); while (w == pat[p]);
            press(w);
            alive = 0;
          end else if (c < 7) begin
            wait_phase(M_IDLE, "rand_timeout");
            alive = 0;
          end else begin
            if (p == len - 1) rnd = 4'($urandom);
            press(pat[p]);
            if (p == len - 1 && m_ph != M_APPEND) alive = 0;
          end
        end
      end
      wait_phase(M_IDLE, "rand_idle");
      tick($urandom_range(0, 3));
    end

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
